inert_intf: RTL
===============

Name: inert_intf

Overview:
- Upstream stage of the PID balance controller; produces its signed 16-bit ptch, ptch_rt and single-cycle vld inputs.
- Configures the 6-axis inertial sensor after reset, then, on each sensor data-ready interrupt, reads pitch rate and Z-acceleration through the existing SPI master (wrt/done handshake).
- Fuses the two readings in a complementary-filter integrator.

Parameters:
fast_sim, 1'b1, 1 = init wait timer 10 bits; 0 = 16 bits
PTCH_RT_OFFSET, 16'sh0050, gyro pitch-rate zero offset subtracted from raw rate
AZ_OFFSET, 16'sh00A0, accel Z zero offset subtracted from raw AZ
FUSION_GAIN, 27'sd1024, per-sample accel-correction step applied to integrator

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
INT  in  1  sensor data-ready, asynchronous to clk
done  in  1  SPI master transaction complete, 1-cycle pulse
inert_data  in  16  SPI read data; low byte valid when done
wrt  out  1  1-cycle pulse starting an SPI transaction
cmd  out  16  SPI command word; held stable from wrt until done
ptch  out  16  signed fused pitch, integrator bits [26:11]
ptch_rt  out  16  signed offset-compensated pitch rate
vld  out  1  1-cycle pulse: ptch/ptch_rt updated this cycle

Behaviour:
- Reset: wrt=0, cmd=0, vld=0, ptch=0, ptch_rt=0, integrator=0, all holding registers=0, FSM=INIT_WAIT, timer=0.
- INT passes through a 2-flop synchroniser into INT_ff2; synchronised-rising-edge detection is not used: a read sequence starts whenever INT_ff2=1 in state IDLE.
- INIT_WAIT: timer counts up every clk; on all-ones (fast_sim: 10'h3FF, else 16'hFFFF) go to CFG0 and pulse wrt.
- Config writes, each issued by a 1-cycle wrt and completed by done: CFG0 cmd=16'h0D02 (INT enable), CFG1 16'h1053 (accel 208Hz), CFG2 16'h1150 (gyro 208Hz), CFG3 16'h1460 (rounding). On done from CFG3 go to IDLE.
- IDLE: when INT_ff2=1, issue reads in order, each wrt then wait for done, capturing inert_data[7:0] on done:
  - RD_PL 16'hA2xx (ptch_rt low)
  - RD_PH 16'hA3xx (ptch_rt high)
  - RD_AL 16'hACxx (AZ low)
  - RD_AH 16'hADxx (AZ high)
  - xx = 8'h00.
- On done in RD_AH: go to INTEG (1 cycle), then IDLE. INTEG performs the update; vld asserts on the following cycle, coincident with the new ptch/ptch_rt values.
- Arithmetic (all signed):
  - rt_comp = {PH,PL} - PTCH_RT_OFFSET (16b, wrap).
  - az_comp = {AH,AL} - AZ_OFFSET (16b).
  - prod = az_comp * 327 (25b).
  - ptch_acc = sign-extend prod[24:13] to 16b.
  - fuse = (ptch_acc > ptch) ? +FUSION_GAIN : -FUSION_GAIN.
  - integrator(27b) <= integrator - sign_ext27(rt_comp) + fuse (wraps, no saturation).
  - ptch_rt <= rt_comp.
  - ptch = integrator[26:11].
- wrt never asserts while a transaction is outstanding. done arriving in any non-waiting state is ignored.
- INT held high continuously causes back-to-back read sequences: one vld per 4 SPI transactions.
- Reset mid-transaction: immediate return to INIT_WAIT; the full configuration is reissued.

Optional Feature:
INERT_TIMEOUT_EN:
- Defined: a 10-bit watchdog clears on every wrt and increments while awaiting done. At 10'h3FF the FSM abandons the transaction and returns to INIT_WAIT (timer cleared, full reconfiguration). No vld is produced for the aborted sample; the integrator is retained.
- Undefined: no watchdog; the FSM waits for done indefinitely.

Test Plan:
- Reset, fast_sim=1, SPI model acks each wrt after 20 cycles -> first wrt at cycle 1024 after reset release with cmd=16'h0D02, then 16'h1053, 16'h1150, 16'h1460 in order; no vld.
- After init, INT=1 for one sample with reads PL=8'h50, PH=8'h00, AL=8'hA0, AH=8'h00 -> cmd sequence A200,A300,AC00,AD00. vld pulses once; ptch_rt=0; integrator=-1024; ptch=16'hFFFF (ptch_acc 0 > ptch 0 false).
- Repeated samples with rate raw=16'h0850, AZ at offset -> ptch_rt=16'h0800; integrator decreases by 2048+1024 per sample until ptch_acc > ptch, then by 2048-1024.
- INT held high -> exactly one vld per 4 done pulses; cmd never changes between wrt and its done.
- rst_n low during RD_AH wait -> outputs return to 0, FSM restarts at INIT_WAIT, CFG0 reissued after 1024 cycles.
- INERT_TIMEOUT_EN defined, done withheld after RD_PH wrt -> after 1023 cycles FSM returns to INIT_WAIT, no vld, ptch unchanged; undefined -> FSM remains in RD_PH wait.

Source files
------------

// File: rtl/inert_intf.sv
// inert_intf: inertial sensor front end for the pitch balance controller.
//
// Configures the 6-axis sensor once reset is released. After that, each time
// the synchronised data-ready line is high in IDLE it reads the pitch rate and
// the Z acceleration over the SPI master (wrt/done handshake). The two readings
// are fused in a complementary-filter integrator.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   INT         sensor data-ready, asynchronous to clk
//   done        SPI transaction complete (1-cycle pulse)
//   inert_data  SPI read data; only the low byte is used
//   wrt         1-cycle pulse that starts an SPI transaction
//   cmd         SPI command word, held from wrt until done
//   ptch        signed fused pitch, integrator bits [26:11]
//   ptch_rt     signed offset-compensated pitch rate
//   vld         1-cycle pulse marking new ptch/ptch_rt
//
// Build option: define INERT_TIMEOUT_EN to add a 10-bit SPI watchdog that
// abandons a stuck transaction and restarts the full configuration.
//
// state      | meaning
// INIT_WAIT  | power-up delay before configuring the sensor
// CFG0..CFG3 | configuration write in flight, waiting for done
// IDLE       | waiting for data-ready
// RD_PL/PH   | pitch-rate low/high byte read in flight
// RD_AL/AH   | accel-Z low/high byte read in flight
// INTEG      | one-cycle integrator update
module inert_intf #(
  parameter bit                 fast_sim       = 1'b1,
  parameter logic signed [15:0] PTCH_RT_OFFSET = 16'sh0050,
  parameter logic signed [15:0] AZ_OFFSET      = 16'sh00A0,
  parameter logic signed [26:0] FUSION_GAIN    = 27'sd1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] inert_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch,
  output logic [15:0] ptch_rt,
  output logic        vld
);

  localparam logic [3:0] S_INIT_WAIT = 4'd0;
  localparam logic [3:0] S_CFG0      = 4'd1;
  localparam logic [3:0] S_CFG1      = 4'd2;
  localparam logic [3:0] S_CFG2      = 4'd3;
  localparam logic [3:0] S_CFG3      = 4'd4;
  localparam logic [3:0] S_IDLE      = 4'd5;
  localparam logic [3:0] S_RD_PL     = 4'd6;
  localparam logic [3:0] S_RD_PH     = 4'd7;
  localparam logic [3:0] S_RD_AL     = 4'd8;
  localparam logic [3:0] S_RD_AH     = 4'd9;
  localparam logic [3:0] S_INTEG     = 4'd10;

  // The short wait is kept in the same 16-bit counter; only the terminal value changes.
  localparam logic [15:0] TIMER_TOP = fast_sim ? 16'h03FF : 16'hFFFF;

  logic [3:0]         state;
  logic [15:0]        timer;
  logic               int_ff1, int_ff2;
  logic [7:0]         pl, ph, al, ah;
  logic signed [26:0] integ;

  logic signed [15:0] rt_comp, az_comp, ptch_acc, ptch_s;
  logic signed [24:0] prod;
  logic signed [26:0] fuse, integ_nxt;
  logic               wait_st;
  logic               unused_bits;

  assign rt_comp   = $signed({ph, pl}) - PTCH_RT_OFFSET;
  assign az_comp   = $signed({ah, al}) - AZ_OFFSET;
  assign prod      = az_comp * 25'sd327;
  assign ptch_acc  = {{4{prod[24]}}, prod[24:13]};
  assign ptch_s    = integ[26:11];
  assign fuse      = (ptch_acc > ptch_s) ? FUSION_GAIN : -FUSION_GAIN;
  assign integ_nxt = integ - {{11{rt_comp[15]}}, rt_comp} + fuse;
  assign ptch      = ptch_s;
  assign wait_st   = (state >= S_CFG0 && state <= S_RD_AH && state != S_IDLE);
  assign unused_bits = ^{inert_data[15:8], prod[12:0]};

`ifdef INERT_TIMEOUT_EN
  logic [9:0] wdog;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       wdog <= '0;
    else if (wrt)     wdog <= '0;
    else if (wait_st) wdog <= wdog + 10'd1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_ff1 <= 1'b0;
      int_ff2 <= 1'b0;
    end else begin
      int_ff1 <= INT;
      int_ff2 <= int_ff1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_INIT_WAIT;
      timer   <= '0;
      wrt     <= 1'b0;
      cmd     <= '0;
      vld     <= 1'b0;
      ptch_rt <= '0;
      integ   <= '0;
      pl      <= '0;
      ph      <= '0;
      al      <= '0;
      ah      <= '0;
    end else begin
      wrt <= 1'b0;
      vld <= 1'b0;
      case (state)
        S_INIT_WAIT: begin
          if (timer == TIMER_TOP) begin
            timer <= '0;
            state <= S_CFG0;
            wrt   <= 1'b1;
            cmd   <= 16'h0D02;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        S_CFG0: if (done) begin state <= S_CFG1; wrt <= 1'b1; cmd <= 16'h1053; end
        S_CFG1: if (done) begin state <= S_CFG2; wrt <= 1'b1; cmd <= 16'h1150; end
        S_CFG2: if (done) begin state <= S_CFG3; wrt <= 1'b1; cmd <= 16'h1460; end
        S_CFG3: if (done) state <= S_IDLE;
        // Level-sensitive on purpose: INT still high after a sample starts the next one.
        S_IDLE: if (int_ff2) begin state <= S_RD_PL; wrt <= 1'b1; cmd <= 16'hA200; end
        S_RD_PL: if (done) begin
          pl <= inert_data[7:0]; state <= S_RD_PH; wrt <= 1'b1; cmd <= 16'hA300;
        end
        S_RD_PH: if (done) begin
          ph <= inert_data[7:0]; state <= S_RD_AL; wrt <= 1'b1; cmd <= 16'hAC00;
        end
        S_RD_AL: if (done) begin
          al <= inert_data[7:0]; state <= S_RD_AH; wrt <= 1'b1; cmd <= 16'hAD00;
        end
        S_RD_AH: if (done) begin
          ah <= inert_data[7:0]; state <= S_INTEG;
        end
        S_INTEG: begin
          integ   <= integ_nxt;
          ptch_rt <= rt_comp;
          vld     <= 1'b1;
          state   <= S_IDLE;
        end
        default: state <= S_INIT_WAIT;
      endcase
`ifdef INERT_TIMEOUT_EN
      // A stuck transaction drops the sample; the integrator is kept.
      if (wait_st && wdog == 10'h3FF) begin
        state <= S_INIT_WAIT;
        timer <= '0;
        wrt   <= 1'b0;
      end
`endif
    end
  end

endmodule
